mmio_console_responder: RTL and testbench

Memory-mapped peripheral that sits on the target side of the single-cycle core's data-memory bus. It decodes a 16-byte window, answers loads combinationally within the same cycle, and commits stores on the clock edge. Byte stores to a TX register are buffered in a FIFO that a downstream console sink drains over a valid/ready handshake. A status register and a free-running cycle counter are readable by software.

---
 rtl/mmio_console_pkg.sv | 31 +++
 rtl/byte_fifo.sv | 51 +++++
 rtl/mmio_console_responder.sv | 91 +++++++++
 tb/tb_mmio_console_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_console_pkg.sv
// rtl/mmio_console_pkg.sv - shared constants and status packing for the MMIO console responder
package mmio_console_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h1100_0000;
  localparam int          DEFAULT_FIFO_DEPTH = 8;

  // Word offsets within the 16-byte window (bus_address[3:2])
  localparam logic [1:0] TXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] CYCLE_OFS  = 2'd2;

  // STATUS register layout
  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 8;

  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       overflow,
                                              input logic [7:0] count);
    logic [31:0] s;
    s = '0;
    s[STATUS_EMPTY_BIT]          = empty;
    s[STATUS_FULL_BIT]           = full;
    s[STATUS_OVERFLOW_BIT]       = overflow;
    s[STATUS_COUNT_LSB +: 8]     = count;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - 8-bit synchronous FIFO with occupancy count and zeroed head when empty
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when the head leaves on the same edge
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage array needs no reset; empty gating hides stale entries
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_console_responder.sv
// rtl/mmio_console_responder.sv - MMIO window with TX byte FIFO, status/overflow and cycle counter
module mmio_console_responder
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [3:0]  bus_byte_enable,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        hit,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    offset;
  logic          wr_lane0;
  logic          tx_push;
  logic          tx_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          overflow_set;
  logic          overflow_clear;
  logic [31:0]   cycle_count;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign hit      = (bus_address[31:4] == BASE_ADDR[31:4]);
  assign offset   = bus_address[3:2];
  assign wr_lane0 = hit & bus_write_enable & bus_byte_enable[0];
  assign tx_push  = wr_lane0 & (offset == TXDATA_OFS);
  assign tx_valid = ~fifo_empty;
  assign tx_pop   = tx_valid & tx_ready;

  // Dropped byte only when full and the sink is not freeing a slot this edge
  assign overflow_set   = tx_push & fifo_full & ~tx_pop;
  assign overflow_clear = wr_lane0 & (offset == STATUS_OFS) & bus_write_data[STATUS_OVERFLOW_BIT];

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (tx_push),
    .push_data (bus_write_data[7:0]),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else          overflow <= overflow_set | (overflow & ~overflow_clear);
  end

  // Free-running cycle counter, wraps at 2^32
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cycle_count <= '0;
    else          cycle_count <= cycle_count + 32'd1;
  end

  assign status_word = pack_status(fifo_empty, fifo_full, overflow, 8'(fifo_count));

  // Load mux reflects pre-edge state, so a same-cycle store is not yet visible
  always_comb begin
    bus_read_data = 32'h0;
    if (hit && bus_read_enable) begin
      case (offset)
        STATUS_OFS: bus_read_data = status_word;
        CYCLE_OFS:  bus_read_data = cycle_count;
        default:    bus_read_data = 32'h0;
      endcase
    end
  end

  assign unused_bits = ^{bus_address[1:0], bus_byte_enable[3:1], bus_write_data[31:8]};

endmodule

// File: tb/tb_mmio_console_responder.sv
// tb/tb_mmio_console_responder.sv - self-checking bench with queue-based reference model
module tb_mmio_console_responder;

  localparam logic [31:0] BASE  = 32'h1100_0000;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bus_address = '0;
  logic        bus_read_enable = 1'b0;
  logic        bus_write_enable = 1'b0;
  logic [3:0]  bus_byte_enable = '0;
  logic [31:0] bus_write_data = '0;
  logic [31:0] bus_read_data;
  logic        hit;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cycle = '0;

  mmio_console_responder dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .bus_address      (bus_address),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_byte_enable  (bus_byte_enable),
    .bus_write_data   (bus_write_data),
    .bus_read_data    (bus_read_data),
    .hit              (hit),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_ready         (tx_ready)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    n = m_q.size();
    return (32'(n) << 8) | (m_ovf ? 32'h4 : 32'h0) |
           ((n == DEPTH) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
  endfunction

  // Model reset follows the asynchronous reset assertion
  always @(negedge reset_n) begin
    m_q.delete();
    m_ovf   = 1'b0;
    m_cycle = '0;
  end

  // Model update on each edge using the inputs held over the cycle
  always @(posedge clock) begin
    logic in_win, is_push, is_clear, is_pop, was_full, ovf_new;
    if (reset_n) begin
      in_win   = (bus_address[31:4] == BASE[31:4]);
      is_push  = in_win && bus_write_enable && bus_byte_enable[0] && (bus_address[3:2] == 2'd0);
      is_clear = in_win && bus_write_enable && bus_byte_enable[0] && (bus_address[3:2] == 2'd1)
                 && bus_write_data[2];
      is_pop   = (m_q.size() != 0) && tx_ready;
      was_full = (m_q.size() == DEPTH);
      ovf_new  = is_push && was_full && !is_pop;
      if (is_pop) void'(m_q.pop_front());
      if (is_push && !ovf_new) m_q.push_back(bus_write_data[7:0]);
      m_ovf   = ovf_new || (m_ovf && !is_clear);
      m_cycle = m_cycle + 32'd1;
    end
  end

  // Compare all outputs mid-cycle against the model
  always @(negedge clock) begin
    logic        e_hit;
    logic [31:0] e_rd;
    e_hit = (bus_address[31:4] == BASE[31:4]);
    e_rd  = 32'h0;
    if (e_hit && bus_read_enable) begin
      if (bus_address[3:2] == 2'd1)      e_rd = model_status();
      else if (bus_address[3:2] == 2'd2) e_rd = m_cycle;
    end
    chk("hit", {31'b0, hit}, {31'b0, e_hit});
    chk("read_data", bus_read_data, e_rd);
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
    chk("tx_data", {24'b0, tx_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
  end

  task automatic bus(input logic [31:0] a, input logic re, input logic we,
                     input logic [3:0] be, input logic [31:0] wd);
    @(posedge clock);
    #1;
    bus_address      = a;
    bus_read_enable  = re;
    bus_write_enable = we;
    bus_byte_enable  = be;
    bus_write_data   = wd;
  endtask

  task automatic idle();
    bus(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [7:0] drain_exp[8];
    logic [31:0] a;
    int r;
    drain_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h5A};

    // Reset state
    idle();
    bus(BASE + 32'h8, 1'b1, 1'b0, 4'h0, 32'h0);
    #3;
    chk("rst_cycle", bus_read_data, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);

    bus(BASE + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
    reset_n = 1'b1;
    #3;
    chk("status_after_reset", bus_read_data, 32'h0000_0001);
    idle();
    idle();
    bus(BASE + 32'h8, 1'b1, 1'b0, 4'h0, 32'h0);
    #3;
    chk("cycle_3", bus_read_data, 32'd3);

    // Two bytes with the sink stalled, then drain
    tx_ready = 1'b0;
    bus(BASE, 1'b0, 1'b1, 4'h1, 32'h48);
    #3;
    chk("no_fall_through", {31'b0, tx_valid}, 32'h0);
    bus(BASE, 1'b0, 1'b1, 4'h1, 32'h69);
    #3;
    chk("tx_valid_rise", {31'b0, tx_valid}, 32'h1);
    chk("head_48_held", {24'b0, tx_data}, 32'h48);
    bus(BASE + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
    #3;
    chk("status_two", bus_read_data, 32'h0000_0200);
    idle();
    tx_ready = 1'b1;
    #3;
    chk("drain_48", {24'b0, tx_data}, 32'h48);
    idle();
    #3;
    chk("drain_69", {24'b0, tx_data}, 32'h69);
    idle();
    #3;
    chk("drained_empty", {31'b0, tx_valid}, 32'h0);

    // Fill, overflow, clear
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus(BASE, 1'b0, 1'b1, 4'h1, 32'h30 + 32'(i));
    bus(BASE, 1'b0, 1'b1, 4'h1, 32'hEE);
    bus(BASE + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
    #3;
    chk("status_overflow", bus_read_data, 32'h0000_0806);
    bus(BASE + 32'h4, 1'b1, 1'b1, 4'h1, 32'h4);
    #3;
    chk("clear_reads_prewrite", bus_read_data, 32'h0000_0806);
    bus(BASE + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
    #3;
    chk("status_cleared", bus_read_data, 32'h0000_0802);

    // Push and pop together while full
    bus(BASE, 1'b0, 1'b1, 4'h1, 32'h5A);
    tx_ready = 1'b1;
    #3;
    chk("full_pushpop_head", {24'b0, tx_data}, 32'h30);
    bus(BASE + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
    tx_ready = 1'b0;
    #3;
    chk("full_pushpop_status", bus_read_data, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      idle();
      tx_ready = 1'b1;
      #3;
      chk("drain_order", {24'b0, tx_data}, {24'b0, drain_exp[i]});
    end
    idle();
    tx_ready = 1'b0;
    #3;
    chk("drain_done", {31'b0, tx_valid}, 32'h0);

    // Lane-masked store and out-of-window access
    bus(BASE, 1'b0, 1'b1, 4'b0010, 32'h77);
    #3;
    chk("hit_in_window", {31'b0, hit}, 32'h1);
    bus(BASE + 32'h10, 1'b1, 1'b1, 4'h1, 32'h55);
    #3;
    chk("hit_outside", {31'b0, hit}, 32'h0);
    chk("read_outside", bus_read_data, 32'h0);
    chk("lane_mask_no_push", {31'b0, tx_valid}, 32'h0);
    bus(BASE + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
    #3;
    chk("status_still_empty", bus_read_data, 32'h0000_0001);

    // Reset in the middle of a drain
    for (int i = 0; i < 5; i++) bus(BASE, 1'b0, 1'b1, 4'h1, 32'hA0 + 32'(i));
    idle();
    tx_ready = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_drop", {31'b0, tx_valid}, 32'h0);
    bus(BASE + 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
    reset_n  = 1'b1;
    tx_ready = 1'b0;
    #3;
    chk("status_after_midreset", bus_read_data, 32'h0000_0001);

    // Randomized traffic, alternating sink pressure, occasional reset
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE | 32'($urandom_range(0, 15));
      else if (r == 7) a = BASE + 32'h10;
      else if (r == 8) a = BASE - 32'h4;
      else             a = $urandom;
      bus(a, 1'($urandom), 1'($urandom), 4'($urandom) | (($urandom_range(0, 3) != 0) ? 4'h1 : 4'h0),
          $urandom);
      tx_ready = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      reset_n  = ($urandom_range(0, 399) != 0);
    end
    idle();
    reset_n = 1'b1;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
